prv_trap_controller: RTL and testbench

- Machine-mode trap responder on the privilege side of the 5-stage pipeline's privilege interface.
- Consumes committed exception flags, epc, badaddr and ret from the pipeline hazard unit. Produces intr, insert_pc and priv_pc back to the pipeline.
- Owns the trap CSRs: mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause, mtval.
- Sequences each redirect with a hold-until-clear handshake.

---
 rtl/prv_trap_controller.sv | 201 ++++++++++++++++++++
 tb/tb_prv_trap_controller.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prv_trap_controller.sv
// prv_trap_controller
//   Machine-mode trap responder. It takes the exception flags, epc, badaddr
//   and ret of the instruction committing in M. It raises a redirect
//   (insert_pc/priv_pc) and holds it until the pipeline reports pipe_clear.
//   It owns mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause and mtval.
//
// Ports
//   CLK, nRST                 clock, asynchronous active-low reset
//   wb_enable                 instruction in M commits this cycle
//   fault_insn .. env_m       exception flags of the committing instruction
//   ret                       committing instruction is MRET
//   epc, badaddr              PC / faulting address of committing instruction
//   ext_int,timer_int,soft_int level-sensitive interrupt sources
//   pipe_clear                pipeline has flushed for the current redirect
//   intr                      enabled interrupt pending (0 while redirecting)
//   insert_pc, priv_pc        redirect request and target
//   csr_wen/addr/wdata/rdata  CSR access port (rdata combinational)
//
// Configuration
//   PRV_VECTORED_INTR_EN  when defined, mtvec[0]=1 sends interrupts to
//                         base + 4*cause; otherwise every trap uses the base.
module prv_trap_controller #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        wb_enable,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        fault_l,
  input  logic        mal_l,
  input  logic        fault_s,
  input  logic        mal_s,
  input  logic        breakpoint,
  input  logic        env_m,
  input  logic        ret,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic        ext_int,
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        pipe_clear,
  output logic        intr,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  input  logic        csr_wen,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

`ifdef PRV_VECTORED_INTR_EN
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

  state_t      state, next_state;
  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mepc_q, mcause_q, mtval_q;
  logic [31:0] mip, pend;
  logic        int_pend, exc, commit;
  logic        take_trap, take_int, take_ret;
  logic [3:0]  exc_code, int_code;
  logic        exc_tval;
  logic [31:0] trap_cause, trap_target, mtvec_base;

  assign mip      = {20'd0, ext_int, 3'd0, timer_int, 3'd0, soft_int, 3'd0};
  assign pend     = mip & mie_q;
  assign int_pend = mstatus_mie & (|pend);
  assign exc      = fault_insn | mal_insn | illegal_insn | fault_l | mal_l |
                    fault_s | mal_s | breakpoint | env_m;
  assign commit   = (state == IDLE) & wb_enable;

  assign take_int  = commit & ~exc & int_pend;
  assign take_trap = commit & (exc | int_pend);
  assign take_ret  = commit & ~exc & ~int_pend & ret;

  // Exception priority chain; exc_tval marks causes that report badaddr.
  always_comb begin
    exc_code = 4'd0;
    exc_tval = 1'b0;
    if (breakpoint)        exc_code = 4'd3;
    else if (fault_insn) begin exc_code = 4'd1;  exc_tval = 1'b1; end
    else if (mal_insn)   begin exc_code = 4'd0;  exc_tval = 1'b1; end
    else if (illegal_insn)     exc_code = 4'd2;
    else if (env_m)            exc_code = 4'd11;
    else if (mal_s)      begin exc_code = 4'd6;  exc_tval = 1'b1; end
    else if (mal_l)      begin exc_code = 4'd4;  exc_tval = 1'b1; end
    else if (fault_s)    begin exc_code = 4'd7;  exc_tval = 1'b1; end
    else if (fault_l)    begin exc_code = 4'd5;  exc_tval = 1'b1; end
  end

  always_comb begin
    int_code = 4'd7;
    if (pend[11])     int_code = 4'd11;
    else if (pend[3]) int_code = 4'd3;
  end

  assign trap_cause = take_int ? {1'b1, 27'd0, int_code} : {28'd0, exc_code};
  assign mtvec_base = {mtvec_q[31:2], 2'b00};

`ifdef PRV_VECTORED_INTR_EN
  assign trap_target = (take_int && mtvec_q[0]) ?
                       mtvec_base + {26'd0, int_code, 2'b00} : mtvec_base;
`else
  assign trap_target = mtvec_base;
`endif

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and outputs
  always_comb begin
    next_state = state;
    insert_pc  = 1'b0;
    intr       = 1'b0;
    case (state)
      IDLE: begin
        intr = int_pend;
        if (take_trap || take_ret) next_state = REDIRECT;
      end
      REDIRECT: begin
        insert_pc = 1'b1;
        if (pipe_clear) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // CSR file. Software writes are applied first; the trap/return
  // assignments that follow override any field they share.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= RESET_MTVEC & 32'hFFFF_FFFC;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      priv_pc      <= '0;
    end else begin
      if (csr_wen) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
          end
          ADDR_MIE:    mie_q    <= csr_wdata & 32'h0000_0888;
          ADDR_MTVEC:  mtvec_q  <= csr_wdata & MTVEC_MASK;
          ADDR_MEPC:   mepc_q   <= csr_wdata & 32'hFFFF_FFFC;
          ADDR_MCAUSE: mcause_q <= csr_wdata;
          ADDR_MTVAL:  mtval_q  <= csr_wdata;
          default: ;
        endcase
      end
      if (take_trap) begin
        mepc_q       <= epc & 32'hFFFF_FFFC;
        mcause_q     <= trap_cause;
        mtval_q      <= (!take_int && exc_tval) ? badaddr : '0;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        priv_pc      <= trap_target;
      end else if (take_ret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
        priv_pc      <= mepc_q;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      ADDR_MIE:     csr_rdata = mie_q;
      ADDR_MTVEC:   csr_rdata = mtvec_q;
      ADDR_MEPC:    csr_rdata = mepc_q;
      ADDR_MCAUSE:  csr_rdata = mcause_q;
      ADDR_MTVAL:   csr_rdata = mtval_q;
      ADDR_MIP:     csr_rdata = mip;
      default:      csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_prv_trap_controller.sv
// Testbench for prv_trap_controller: directed steps followed by random
// commits, interrupts, flushes and CSR traffic, all checked against a
// behavioural model of the trap rules.
module tb_prv_trap_controller;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        wb_enable, fault_insn, mal_insn, illegal_insn, fault_l, mal_l;
  logic        fault_s, mal_s, breakpoint, env_m, ret;
  logic [31:0] epc, badaddr;
  logic        ext_int, timer_int, soft_int, pipe_clear;
  logic        intr, insert_pc;
  logic [31:0] priv_pc;
  logic        csr_wen;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  bit          m_status_mie, m_status_mpie, m_busy;
  logic [31:0] m_ie, m_mtvec, m_mepc, m_mcause, m_mtval, m_ppc;

  prv_trap_controller #(.RESET_MTVEC(32'h0000_0200)) dut (
    .CLK(CLK), .nRST(nRST), .wb_enable(wb_enable),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .fault_l(fault_l), .mal_l(mal_l), .fault_s(fault_s), .mal_s(mal_s),
    .breakpoint(breakpoint), .env_m(env_m), .ret(ret),
    .epc(epc), .badaddr(badaddr),
    .ext_int(ext_int), .timer_int(timer_int), .soft_int(soft_int),
    .pipe_clear(pipe_clear), .intr(intr), .insert_pc(insert_pc),
    .priv_pc(priv_pc), .csr_wen(csr_wen), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_mip();
    return (32'(ext_int) << 11) | (32'(timer_int) << 7) | (32'(soft_int) << 3);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_status_mpie) << 7) | (32'(m_status_mie) << 3);
      12'h304: return m_ie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip();
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_status_mie = 0; m_status_mpie = 0; m_busy = 0;
    m_ie = 0; m_mtvec = 32'h200; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_ppc = 0;
  endtask

  task automatic idle_inputs();
    wb_enable = 0; fault_insn = 0; mal_insn = 0; illegal_insn = 0;
    fault_l = 0; mal_l = 0; fault_s = 0; mal_s = 0; breakpoint = 0; env_m = 0;
    ret = 0; epc = 0; badaddr = 0; ext_int = 0; timer_int = 0; soft_int = 0;
    pipe_clear = 0; csr_wen = 0; csr_addr = 0; csr_wdata = 0;
  endtask

  // One clock edge: predict from the current inputs, advance, then compare.
  task automatic tick(input string tag);
    bit          fl[9];
    int unsigned ecode[9] = '{3, 1, 0, 2, 11, 6, 4, 7, 5};
    int unsigned icode[3] = '{11, 3, 7};
    int unsigned code = 0;
    bit          t_exc = 0, t_int = 0, t_ret = 0;
    bit          o_mie, o_mpie, o_busy;
    logic [31:0] o_mtvec, o_mepc, pend, tgt;
    logic [11:0] raddr;
    logic [11:0] addrs[8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                              12'h342, 12'h343, 12'h344, 12'h7C0};
    fl = '{breakpoint, fault_insn, mal_insn, illegal_insn, env_m,
           mal_s, mal_l, fault_s, fault_l};
    o_mie = m_status_mie; o_mpie = m_status_mpie; o_busy = m_busy;
    o_mtvec = m_mtvec; o_mepc = m_mepc;
    pend = m_ie & m_mip();
    if (!o_busy && wb_enable) begin
      for (int i = 0; i < 9; i++)
        if (fl[i] && !t_exc) begin t_exc = 1; code = ecode[i]; end
      if (!t_exc && o_mie && pend != 0)
        for (int i = 0; i < 3; i++)
          if (pend[icode[i]] && !t_int) begin t_int = 1; code = icode[i]; end
      if (!t_exc && !t_int && ret) t_ret = 1;
    end
    if (csr_wen) begin
      case (csr_addr)
        12'h300: begin m_status_mie = csr_wdata[3]; m_status_mpie = csr_wdata[7]; end
        12'h304: m_ie = csr_wdata & 32'h888;
`ifdef PRV_VECTORED_INTR_EN
        12'h305: m_mtvec = csr_wdata & ~32'h2;
`else
        12'h305: m_mtvec = csr_wdata & ~32'h3;
`endif
        12'h341: m_mepc = csr_wdata & ~32'h3;
        12'h342: m_mcause = csr_wdata;
        12'h343: m_mtval = csr_wdata;
        default: ;
      endcase
    end
    if (t_exc || t_int) begin
      m_mepc = epc & ~32'h3;
      m_mcause = t_int ? (32'h8000_0000 | code) : code;
      m_mtval = (t_exc && (code inside {0, 1, 4, 5, 6, 7})) ? badaddr : 32'd0;
      m_status_mpie = o_mie;
      m_status_mie = 0;
      tgt = o_mtvec & ~32'h3;
`ifdef PRV_VECTORED_INTR_EN
      if (t_int && o_mtvec[0]) tgt = tgt + 4 * code;
`endif
      m_ppc = tgt;
      m_busy = 1;
    end else if (t_ret) begin
      m_status_mie = o_mpie;
      m_status_mpie = 1;
      m_ppc = o_mepc;
      m_busy = 1;
    end else if (o_busy && pipe_clear) begin
      m_busy = 0;
    end
    @(posedge CLK);
    #1;
    chk({tag, ".insert_pc"}, 32'(insert_pc), 32'(m_busy));
    chk({tag, ".priv_pc"}, priv_pc, m_ppc);
    chk({tag, ".intr"}, 32'(intr),
        32'(!m_busy && m_status_mie && ((m_ie & m_mip()) != 0)));
    csr_wen = 0;
    raddr = addrs[$urandom_range(0, 7)];
    csr_addr = raddr;
    #1;
    chk({tag, ".rdata"}, csr_rdata, m_read(raddr));
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge CLK);
    csr_wen = 0;
    csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_wen = 1; csr_addr = a; csr_wdata = d;
    tick("wr");
  endtask

  task automatic flush(input string tag);
    idle_inputs();
    pipe_clear = 1;
    tick(tag);
    pipe_clear = 0;
  endtask

  initial begin
    idle_inputs();
    nRST = 0;
    m_reset();
    repeat (2) @(negedge CLK);
    chk("rst.insert_pc", 32'(insert_pc), 32'd0);
    chk("rst.priv_pc", priv_pc, 32'd0);
    nRST = 1;
    chk_csr("rst.mtvec", 12'h305, 32'h200);
    chk_csr("rst.mstatus", 12'h300, 32'h0);
    chk_csr("rst.mcause", 12'h342, 32'h0);

    // Enabled external interrupt is masked by MIE=0
    csr_write(12'h304, 32'h800);
    ext_int = 1;
    tick("mie_masked");
    chk("mie_masked.intr", 32'(intr), 32'd0);
    idle_inputs();

    // Illegal instruction trap with held redirect
    illegal_insn = 1; epc = 32'h1004; wb_enable = 1;
    tick("illegal");
    chk("illegal.redirect", {31'd0, insert_pc}, 32'd1);
    chk("illegal.target", priv_pc, 32'h200);
    idle_inputs();
    tick("illegal_hold1");
    tick("illegal_hold2");
    flush("illegal_clear");
    chk("illegal.dropped", {31'd0, insert_pc}, 32'd0);
    chk_csr("illegal.mepc", 12'h341, 32'h1004);
    chk_csr("illegal.mcause", 12'h342, 32'd2);
    chk_csr("illegal.mtval", 12'h343, 32'd0);
    chk_csr("illegal.mstatus", 12'h300, 32'd0);

    // Misaligned load beats load fault
    mal_l = 1; fault_l = 1; badaddr = 32'h3; epc = 32'h2000; wb_enable = 1;
    tick("mal_l");
    flush("mal_l_clear");
    chk_csr("mal_l.mcause", 12'h342, 32'd4);
    chk_csr("mal_l.mtval", 12'h343, 32'h3);

    // All interrupts pending: MEI wins
    csr_write(12'h300, 32'h8);
    csr_write(12'h304, 32'h888);
    ext_int = 1; timer_int = 1; soft_int = 1; epc = 32'h2000; wb_enable = 1;
    tick("irq");
    flush("irq_clear");
    chk_csr("irq.mcause", 12'h342, 32'h8000_000B);
    chk_csr("irq.mstatus", 12'h300, 32'h80);

    // MRET back to mepc
    ret = 1; wb_enable = 1;
    tick("mret");
    chk("mret.target", priv_pc, 32'h2000);
    flush("mret_clear");
    chk_csr("mret.mstatus", 12'h300, 32'h88);

    // Commits during REDIRECT are ignored
    illegal_insn = 1; epc = 32'h3000; wb_enable = 1;
    tick("hold_trap");
    illegal_insn = 0; env_m = 1;
    for (int i = 0; i < 3; i++) tick("hold_envm");
    pipe_clear = 1;
    tick("hold_clear");
    idle_inputs();
    tick("hold_after");
    chk("hold.single", {31'd0, insert_pc}, 32'd0);
    chk_csr("hold.mcause", 12'h342, 32'd2);
    chk_csr("hold.mepc", 12'h341, 32'h3000);

    // CSR write to mcause in the trap cycle loses to the trap
    breakpoint = 1; wb_enable = 1; epc = 32'h4000;
    csr_wen = 1; csr_addr = 12'h342; csr_wdata = 32'h55;
    tick("wr_vs_trap");
    flush("wr_vs_trap_clear");
    chk_csr("wr_vs_trap.mcause", 12'h342, 32'd3);

    // mtvec low bits and timer interrupt target
    csr_write(12'h305, 32'h201);
    csr_write(12'h300, 32'h8);
    csr_write(12'h304, 32'h80);
`ifdef PRV_VECTORED_INTR_EN
    chk_csr("vec.mtvec", 12'h305, 32'h201);
`else
    chk_csr("vec.mtvec", 12'h305, 32'h200);
`endif
    timer_int = 1; wb_enable = 1; epc = 32'h5000;
    tick("vec_timer");
`ifdef PRV_VECTORED_INTR_EN
    chk("vec.timer_target", priv_pc, 32'h21C);
`else
    chk("vec.timer_target", priv_pc, 32'h200);
`endif
    flush("vec_timer_clear");
    env_m = 1; wb_enable = 1;
    tick("vec_exc");
    chk("vec.exc_target", priv_pc, 32'h200);

    // Reset in the middle of a redirect
    #2;
    nRST = 0;
    #1;
    chk("midrst.insert_pc", {31'd0, insert_pc}, 32'd0);
    chk("midrst.priv_pc", priv_pc, 32'd0);
    idle_inputs();
    m_reset();
    @(negedge CLK);
    nRST = 1;
    chk_csr("midrst.mtvec", 12'h305, 32'h200);
    chk_csr("midrst.mcause", 12'h342, 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [11:0] waddrs[8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'h7C0};
      wb_enable    = ($urandom_range(0, 1) == 1);
      fault_insn   = ($urandom_range(0, 15) == 0);
      mal_insn     = ($urandom_range(0, 15) == 0);
      illegal_insn = ($urandom_range(0, 15) == 0);
      fault_l      = ($urandom_range(0, 15) == 0);
      mal_l        = ($urandom_range(0, 15) == 0);
      fault_s      = ($urandom_range(0, 15) == 0);
      mal_s        = ($urandom_range(0, 15) == 0);
      breakpoint   = ($urandom_range(0, 15) == 0);
      env_m        = ($urandom_range(0, 15) == 0);
      ret          = ($urandom_range(0, 5) == 0);
      epc          = $urandom;
      badaddr      = $urandom;
      ext_int      = ($urandom_range(0, 3) == 0);
      timer_int    = ($urandom_range(0, 3) == 0);
      soft_int     = ($urandom_range(0, 3) == 0);
      pipe_clear   = ($urandom_range(0, 2) == 0);
      csr_wen      = ($urandom_range(0, 3) == 0);
      csr_addr     = waddrs[$urandom_range(0, 7)];
      csr_wdata    = $urandom;
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
